// File: rtl/sram_1rw_req_ctrl_if.sv
// Client-side request/response bundle for the single-port SRAM front end.
// The master drives requests and pops responses; the slave is the controller.
interface sram_1rw_req_ctrl_if #(
    parameter int addr_width_p = 10,
    parameter int data_width_p = 8,
    parameter int mask_width_p = 1
);
    logic                    v_i;
    logic                    w_i;
    logic [addr_width_p-1:0] addr_i;
    logic [data_width_p-1:0] data_i;
    logic [mask_width_p-1:0] mask_i;
    logic                    ready_o;
    logic                    v_o;
    logic [data_width_p-1:0] data_o;
    logic                    yumi_i;

    modport master (
        output v_i, w_i, addr_i, data_i, mask_i, yumi_i,
        input  ready_o, v_o, data_o
    );

    modport slave (
        input  v_i, w_i, addr_i, data_i, mask_i, yumi_i,
        output ready_o, v_o, data_o
    );
endinterface

// File: rtl/sram_1rw_req_ctrl.sv
// RW-port front end for one OpenRAM byte macro: valid/ready requests in,
// read data captured the cycle after the access into a credit-managed FIFO.
module sram_1rw_req_ctrl #(
    parameter int addr_width_p = 10,
    parameter int data_width_p = 8,
    parameter int mask_width_p = 1,
    parameter int els_p        = 3
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    sram_1rw_req_ctrl_if.slave      req_if,
    output logic                    sram_csb_o,
    output logic                    sram_web_o,
    output logic [mask_width_p-1:0] sram_wmask_o,
    output logic [addr_width_p-1:0] sram_addr_o,
    output logic [data_width_p-1:0] sram_din_o,
    input  logic [data_width_p-1:0] sram_dout_i
);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic                    rd_pending_q, rd_pending_d;
    logic [cnt_w_lp-1:0]     count_q, count_d;
    logic [ptr_w_lp-1:0]     head_q, head_d;
    logic [ptr_w_lp-1:0]     tail_q, tail_d;
    logic [data_width_p-1:0] mem_q [els_p];
    logic [cnt_w_lp:0]       outstanding_s;
    logic                    ready_s;
    logic                    fire_s;
    logic                    push_s;
    logic                    pop_s;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        if (p == ptr_w_lp'(els_p - 1)) begin
            return {ptr_w_lp{1'b0}};
        end else begin
            return p + ptr_w_lp'(1);
        end
    endfunction

    // Credit check, handshake and FIFO next-state.
    always_comb begin
        // A read in flight already owns a FIFO slot, so it counts as a credit.
        outstanding_s = {1'b0, count_q} + {{cnt_w_lp{1'b0}}, rd_pending_q};
        ready_s       = reset_n_i & (outstanding_s < (cnt_w_lp + 1)'(els_p));
        fire_s        = req_if.v_i & ready_s;
        push_s        = rd_pending_q;
        pop_s         = req_if.yumi_i & (count_q != {cnt_w_lp{1'b0}});
        rd_pending_d  = fire_s & ~req_if.w_i;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        if (pop_s) begin
            head_d = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        if (push_s) begin
            tail_d = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_pending_q <= 1'b0;
            count_q      <= {cnt_w_lp{1'b0}};
            head_q       <= {ptr_w_lp{1'b0}};
            tail_q       <= {ptr_w_lp{1'b0}};
        end else begin
            rd_pending_q <= rd_pending_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
        end
    end

    // Response storage; macro dout is only valid the cycle after a read.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[tail_q] <= sram_dout_i;
        end
    end

    assign req_if.ready_o = ready_s;
    assign req_if.v_o     = (count_q != {cnt_w_lp{1'b0}});
    assign req_if.data_o  = mem_q[head_q];

    assign sram_csb_o   = ~fire_s;
    assign sram_web_o   = ~(fire_s & req_if.w_i);
    assign sram_addr_o  = req_if.addr_i;
    assign sram_din_o   = req_if.data_i;
    assign sram_wmask_o = req_if.mask_i;

    sram_1rw_req_ctrl_chk #(
        .els_p    (els_p),
        .cnt_w_p  (cnt_w_lp)
    ) u_chk (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push_s),
        .yumi_i    (req_if.yumi_i),
        .v_i       (req_if.v_o),
        .count_i   (count_q)
    );
endmodule

// Protocol and overflow properties of the response FIFO.
module sram_1rw_req_ctrl_chk #(
    parameter int els_p   = 3,
    parameter int cnt_w_p = 2
) (
    input logic               clk_i,
    input logic               reset_n_i,
    input logic               push_i,
    input logic               yumi_i,
    input logic               v_i,
    input logic [cnt_w_p-1:0] count_i
);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(push_i && (count_i == cnt_w_p'(els_p))));

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(yumi_i && !v_i));
endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Randomised bench: queue-based response model plus a behavioural SRAM macro.
module tb_sram_1rw_req_ctrl;
    localparam int A = 10;
    localparam int D = 8;
    localparam int M = 1;
    localparam int E = 3;

    logic clk_i = 1'b0;
    logic reset_n_i;
    always #5 clk_i = ~clk_i;

    sram_1rw_req_ctrl_if #(.addr_width_p(A), .data_width_p(D), .mask_width_p(M)) bus ();

    logic         sram_csb_o;
    logic         sram_web_o;
    logic [M-1:0] sram_wmask_o;
    logic [A-1:0] sram_addr_o;
    logic [D-1:0] sram_din_o;
    logic [D-1:0] sram_dout_i;

    sram_1rw_req_ctrl #(.addr_width_p(A), .data_width_p(D), .mask_width_p(M), .els_p(E)) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .req_if       (bus.slave),
        .sram_csb_o   (sram_csb_o),
        .sram_web_o   (sram_web_o),
        .sram_wmask_o (sram_wmask_o),
        .sram_addr_o  (sram_addr_o),
        .sram_din_o   (sram_din_o),
        .sram_dout_i  (sram_dout_i)
    );

    // Macro model: synchronous write, registered read data
    logic [D-1:0] sram_mem [1024];
    always @(posedge clk_i) begin
        if (!sram_csb_o) begin
            if (!sram_web_o) begin
                if (sram_wmask_o[0]) sram_mem[sram_addr_o] <= sram_din_o;
            end else begin
                sram_dout_i <= sram_mem[sram_addr_o];
            end
        end
    end

    typedef struct { logic [D-1:0] d; int avail; } rsp_t;
    rsp_t         exp_q[$];
    logic [D-1:0] ref_mem [1024];
    int           cyc;
    bit           in_rst;
    logic [D-1:0] got_d[$];
    int           got_c[$];
    int           acc_cnt, rdy_low;
    logic         last_csb, last_web, last_ready;
    logic [M-1:0] last_wmask;
    int           checks, errors;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    function automatic bit model_ready();
        return !in_rst && (exp_q.size() < E);
    endfunction

    function automatic bit model_v();
        return !in_rst && (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    endfunction

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk_i) begin
        bit er, ev, fire;
        er   = model_ready();
        ev   = model_v();
        fire = bus.v_i && er;
        chk("ready_o", 32'(bus.ready_o), 32'(er));
        chk("v_o", 32'(bus.v_o), 32'(ev));
        chk("sram_csb", 32'(sram_csb_o), 32'(!fire));
        chk("sram_web", 32'(sram_web_o), 32'(!(fire && bus.w_i)));
        if (ev) chk("data_o", 32'(bus.data_o), 32'(exp_q[0].d));
        if (fire) begin
            chk("sram_addr", 32'(sram_addr_o), 32'(bus.addr_i));
            chk("sram_din", 32'(sram_din_o), 32'(bus.data_i));
            chk("sram_wmask", 32'(sram_wmask_o), 32'(bus.mask_i));
        end
        if (bus.v_o && bus.yumi_i) begin
            got_d.push_back(bus.data_o);
            got_c.push_back(cyc);
        end
        if (bus.v_i && bus.ready_o) acc_cnt++;
        if (!bus.ready_o) rdy_low++;
        last_csb   = sram_csb_o;
        last_web   = sram_web_o;
        last_wmask = sram_wmask_o;
        last_ready = bus.ready_o;
    end

    task automatic step(input bit v, input bit w, input logic [A-1:0] a,
                        input logic [D-1:0] d, input logic [M-1:0] m, input bit y);
        bit   fire;
        rsp_t r;
        bus.v_i    = v;
        bus.w_i    = w;
        bus.addr_i = a;
        bus.data_i = d;
        bus.mask_i = m;
        bus.yumi_i = y && model_v();
        @(posedge clk_i);
        if (!in_rst) begin
            fire = bus.v_i && model_ready();
            if (bus.yumi_i) void'(exp_q.pop_front());
            if (fire && !bus.w_i) begin
                r.d     = ref_mem[bus.addr_i];
                r.avail = cyc + 2;
                exp_q.push_back(r);
            end
            if (fire && bus.w_i && bus.mask_i[0]) ref_mem[bus.addr_i] = bus.data_i;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n, input bit y);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, A'(0), D'(0), M'(0), y);
    endtask

    initial begin
        int n0, c0, a0, rl0, k;
        checks = 0; errors = 0; cyc = 0; in_rst = 1'b1;
        acc_cnt = 0; rdy_low = 0;
        reset_n_i = 1'b0;
        bus.v_i = 1'b0; bus.w_i = 1'b0; bus.addr_i = '0;
        bus.data_i = '0; bus.mask_i = '0; bus.yumi_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", 32'(bus.ready_o), 32'd0);
        chk("rst_csb", 32'(sram_csb_o), 32'd1);
        reset_n_i = 1'b1; in_rst = 1'b0;
        #1;
        chk("rel_ready", 32'(bus.ready_o), 32'd1);

        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, A'(i), D'(i), M'(1), 1'b0);

        // write then read of 0x155
        step(1'b1, 1'b1, A'(12'h155), D'(8'hA5), M'(1), 1'b0);
        chk("wr_csb", 32'(last_csb), 32'd0);
        chk("wr_web", 32'(last_web), 32'd0);
        n0 = got_d.size(); c0 = cyc;
        step(1'b1, 1'b0, A'(12'h155), D'(0), M'(0), 1'b1);
        idle(4, 1'b1);
        chk("wr_rd_count", 32'(got_d.size()), 32'(n0 + 1));
        if (got_d.size() > n0) begin
            chk("wr_rd_data", 32'(got_d[n0]), 32'h0000_00A5);
            chk("wr_rd_latency", 32'(got_c[n0] - c0), 32'd2);
        end

        // 16 streaming reads
        n0 = got_d.size(); c0 = cyc; rl0 = rdy_low;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, A'(i), D'(0), M'(0), 1'b1);
        idle(3, 1'b1);
        chk("stream_ready", 32'(rdy_low - rl0), 32'd0);
        chk("stream_count", 32'(got_d.size()), 32'(n0 + 16));
        for (int i = 0; i < 16; i++) begin
            if (got_d.size() > n0 + i) begin
                chk("stream_data", 32'(got_d[n0 + i]), 32'(i));
                chk("stream_cycle", 32'(got_c[n0 + i] - c0), 32'(i + 2));
            end
        end

        // backpressure
        n0 = got_d.size(); a0 = acc_cnt;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, A'(i), D'(0), M'(0), 1'b0);
        chk("bp_accepted", 32'(acc_cnt - a0), 32'd3);
        chk("bp_ready_low", 32'(bus.ready_o), 32'd0);
        step(1'b1, 1'b0, A'(9), D'(0), M'(0), 1'b1);
        step(1'b1, 1'b0, A'(10), D'(0), M'(0), 1'b0);
        chk("bp_ready_back", 32'(last_ready), 32'd1);
        idle(6, 1'b1);
        chk("bp_count", 32'(got_d.size()), 32'(n0 + 4));
        if (got_d.size() >= n0 + 4) begin
            chk("bp_d0", 32'(got_d[n0]), 32'd0);
            chk("bp_d1", 32'(got_d[n0 + 1]), 32'd1);
            chk("bp_d2", 32'(got_d[n0 + 2]), 32'd2);
            chk("bp_d3", 32'(got_d[n0 + 3]), 32'd10);
        end

        // reset with two buffered and one pending
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, A'(20 + i), D'(0), M'(0), 1'b0);
        reset_n_i = 1'b0; in_rst = 1'b1; exp_q.delete();
        bus.v_i = 1'b1; bus.w_i = 1'b1;
        #1;
        chk("mid_rst_v", 32'(bus.v_o), 32'd0);
        chk("mid_rst_ready", 32'(bus.ready_o), 32'd0);
        chk("mid_rst_csb", 32'(sram_csb_o), 32'd1);
        chk("mid_rst_web", 32'(sram_web_o), 32'd1);
        n0 = got_d.size();
        step(1'b1, 1'b0, A'(5), D'(0), M'(0), 1'b1);
        step(1'b1, 1'b0, A'(5), D'(0), M'(0), 1'b1);
        reset_n_i = 1'b1; in_rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.ready_o), 32'd1);
        idle(5, 1'b1);
        chk("no_stale", 32'(got_d.size()), 32'(n0));

        // seven reads with random pop gaps
        n0 = got_d.size(); a0 = acc_cnt; k = 0;
        while ((acc_cnt - a0) < 7 && k < 100) begin
            step(1'b1, 1'b0, A'(24 + acc_cnt - a0), D'(0), M'(0), 1'($urandom_range(0, 1)));
            k++;
        end
        chk("wrap_accepted", 32'(acc_cnt - a0), 32'd7);
        idle(10, 1'b1);
        chk("wrap_count", 32'(got_d.size()), 32'(n0 + 7));
        for (int i = 0; i < 7; i++)
            if (got_d.size() > n0 + i) chk("wrap_data", 32'(got_d[n0 + i]), 32'(24 + i));

        // masked-off write leaves old data
        step(1'b1, 1'b1, A'(7), D'(8'h3C), M'(0), 1'b0);
        chk("mask_web", 32'(last_web), 32'd0);
        chk("mask_wmask", 32'(last_wmask), 32'd0);
        n0 = got_d.size();
        step(1'b1, 1'b0, A'(7), D'(0), M'(0), 1'b1);
        idle(4, 1'b1);
        chk("mask_count", 32'(got_d.size()), 32'(n0 + 1));
        if (got_d.size() > n0) chk("mask_old", 32'(got_d[n0]), 32'd7);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), A'($urandom_range(0, 31)),
                 D'($urandom), M'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(8, 1'b1);
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    end
endmodule
